// File: rtl/fault_gen_ctrl_if.sv
// Fault-address handshake between the sequencer and the fault injector.
// Latency: none (plain wires).
// Backpressure: ready from the injector holds valid/addr/idx until accepted.
//   valid : fault address on offer
//   ready : injector accepts the offered address
//   addr  : fault address
//   idx   : 0-based index of the offered fault
interface fault_gen_ctrl_if #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16
);
  logic              valid;
  logic              ready;
  logic [N_BITS-1:0] addr;
  logic [CNT_W-1:0]  idx;

  modport master (output valid, output addr, output idx, input ready);
  modport slave  (input valid, input addr, input idx, output ready);
endinterface

// File: rtl/fault_gen_ctrl.sv
// Sequencer for the lfsr fault-address generator: seed, step, range-check, issue.
// Latency: start -> first valid in S+3 cycles (S = max(steps,1)); >= S+2 cycles between faults.
// Backpressure: ISSUE holds valid/addr/idx with lfsr_en low until fault_if.ready.
//   clk, rst_ni       : clock, async active-low reset
//   start_i, abort_i  : campaign start (ignored while busy), abort (priority, non-IDLE)
//   seed_i, num_faults_i, steps_i, addr_max_i : config sampled on accepted start
//   lfsr_start_o, lfsr_en_o, lfsr_q_i        : control/observe the external lfsr
//   fault_if (master) : valid/ready/addr/idx to the injector
//   busy_o, done_o, err_o : status (done is a 1-cycle pulse, err is sticky)
module fault_gen_ctrl #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [N_BITS-1:0] seed_i,
  input  logic [CNT_W-1:0]  num_faults_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic [N_BITS-1:0] addr_max_i,
  output logic              lfsr_start_o,
  output logic              lfsr_en_o,
  input  logic [N_BITS-1:0] lfsr_q_i,
  fault_gen_ctrl_if.master  fault_if,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, CHECK, ISSUE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [N_BITS-1:0] max_q, max_d;
  logic [N_BITS-1:0] rej_q, rej_d;
  logic [N_BITS-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  // Step counter reload value: steps==0 behaves as a single step.
  logic [STEP_W-1:0] step_init;
  logic [CNT_W-1:0]  cnt_inc;

  assign step_init = (steps_q == '0) ? '0 : steps_q - STEP_W'(1);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    step_d  = step_q;
    max_d   = max_q;
    rej_d   = rej_q;
    addr_d  = addr_q;
    err_d   = err_q;

    if (abort_i && (state_q != IDLE)) begin
      // Abort wins over everything; a handshake in this cycle is dropped.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_d   = num_faults_i;
            steps_d = steps_i;
            max_d   = addr_max_i;
            cnt_d   = '0;
            rej_d   = '0;
            err_d   = 1'b0;
            if (seed_i == '0) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else if (num_faults_i == '0) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
            end
          end
        end
        LOAD: begin
          step_d  = step_init;
          state_d = STEP;
        end
        STEP: begin
          if (step_q == '0) state_d = CHECK;
          else              step_d  = step_q - STEP_W'(1);
        end
        CHECK: begin
          if (lfsr_q_i == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (lfsr_q_i > max_q) begin
            // rej_q all-ones means this is the 2^N_BITS-th consecutive reject.
            if (rej_q == '1) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              rej_d   = rej_q + N_BITS'(1);
              step_d  = step_init;
              state_d = STEP;
            end
          end else begin
            addr_d  = lfsr_q_i;
            rej_d   = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (fault_if.ready) begin
            cnt_d = cnt_inc;
            if (cnt_inc == num_q) begin
              state_d = DONE;
            end else begin
              step_d  = step_init;
              state_d = STEP;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      step_q  <= '0;
      max_q   <= '0;
      rej_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      step_q  <= step_d;
      max_q   <= max_d;
      rej_q   <= rej_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Outputs are flops or pure decodes of the state register.
  assign lfsr_start_o   = (state_q == LOAD);
  assign lfsr_en_o      = (state_q == STEP);
  assign fault_if.valid = (state_q == ISSUE);
  assign fault_if.addr  = addr_q;
  assign fault_if.idx   = cnt_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_fault_gen_ctrl.sv
// Directed bench for fault_gen_ctrl with a scripted lfsr stub.
// Latency: observes every cycle, cycle 0 = the cycle start_i is sampled.
// Backpressure: ready/abort driven per cycle from pattern tables.
module tb_fault_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  seed_i = '0;
  logic [15:0] num_faults_i = '0;
  logic [7:0]  steps_i = '0;
  logic [7:0]  addr_max_i = '0;
  logic        lfsr_start_o, lfsr_en_o, busy_o, done_o, err_o;
  logic [7:0]  lfsr_q;

  fault_gen_ctrl_if #(.N_BITS(8), .CNT_W(16)) fif ();

  fault_gen_ctrl #(.N_BITS(8), .CNT_W(16), .STEP_W(8)) dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .seed_i(seed_i), .num_faults_i(num_faults_i), .steps_i(steps_i),
    .addr_max_i(addr_max_i), .lfsr_start_o(lfsr_start_o), .lfsr_en_o(lfsr_en_o),
    .lfsr_q_i(lfsr_q), .fault_if(fif), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Scripted lfsr: load seed on start, next table entry per step, FF once the table runs out.
  logic [7:0] stub [8];
  int         nstub = 0;
  int         ptr;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '0;
      ptr    <= 0;
    end else if (lfsr_start_o) begin
      lfsr_q <= seed_i;
      ptr    <= 0;
    end else if (lfsr_en_o) begin
      lfsr_q <= (ptr < nstub) ? stub[ptr] : 8'hFF;
      ptr    <= ptr + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  bit          rdy_pat [1024];
  bit          abt_pat [1024];
  logic        v_log [1024], en_log [1024], st_log [1024], dn_log [1024], bz_log [1024], er_log [1024];
  logic [7:0]  a_log [1024];
  logic [15:0] i_log [1024];

  int          first_v, n_v, n_hs, n_done, done_c, n_en, n_start;
  logic [7:0]  hs_addr [8];
  logic [15:0] hs_idx [8];

  task automatic launch(input logic [7:0] sd, input logic [15:0] n, input logic [7:0] st,
                        input logic [7:0] mx);
    seed_i = sd; num_faults_i = n; steps_i = st; addr_max_i = mx;
    start_i = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      rdy_pat[i] = 1'b1;
      abt_pat[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      fif.ready = rdy_pat[c];
      abort_i   = abt_pat[c];
      v_log[c] = fif.valid; en_log[c] = lfsr_en_o; st_log[c] = lfsr_start_o;
      dn_log[c] = done_o; bz_log[c] = busy_o; er_log[c] = err_o;
      a_log[c] = fif.addr; i_log[c] = fif.idx;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    fif.ready = 1'b0;
    abort_i   = 1'b0;
  endtask

  task automatic scan(input int n);
    first_v = -1; n_v = 0; n_hs = 0; n_done = 0; done_c = -1; n_en = 0; n_start = 0;
    for (int c = 0; c < n; c++) begin
      if (v_log[c] === 1'b1) begin
        n_v++;
        if (first_v < 0) first_v = c;
        if (rdy_pat[c] && !abt_pat[c]) begin
          if (n_hs < 8) begin
            hs_addr[n_hs] = a_log[c];
            hs_idx[n_hs]  = i_log[c];
          end
          n_hs++;
        end
      end
      if (dn_log[c] === 1'b1) begin
        if (done_c < 0) done_c = c;
        n_done++;
      end
      if (en_log[c] === 1'b1) n_en++;
      if (st_log[c] === 1'b1) n_start++;
    end
  endtask

  task automatic test_reset;
    logic [28:0] outs;
    #12;
    outs = {fif.valid, lfsr_start_o, lfsr_en_o, busy_o, done_o, err_o, fif.addr, fif.idx};
    n_chk++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_basic;
    logic [7:0] exp_a [3];
    exp_a[0] = 8'h40; exp_a[1] = 8'h20; exp_a[2] = 8'h90;
    stub[0] = 8'h40; stub[1] = 8'h20; stub[2] = 8'h90; nstub = 3;
    launch(8'h01, 16'd3, 8'd1, 8'hFF);
    run(14);
    scan(14);
    n_chk++;
    if (first_v !== 4) begin n_fail++; $display("FAIL basic_first_valid: got c%0d want c4", first_v); end
    n_chk++;
    if (n_hs !== 3) begin n_fail++; $display("FAIL basic_hs_count: got %0d want 3", n_hs); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (hs_addr[k] !== exp_a[k] || hs_idx[k] !== 16'(k)) begin
        n_fail++;
        $display("FAIL basic_fault%0d: got addr %h idx %0d want addr %h idx %0d",
                 k, hs_addr[k], hs_idx[k], exp_a[k], k);
      end
    end
    n_chk++;
    if (done_c !== 11 || n_done !== 1) begin
      n_fail++; $display("FAIL basic_done: got c%0d x%0d want c11 x1", done_c, n_done);
    end
    n_chk++;
    if (n_en !== 3) begin n_fail++; $display("FAIL basic_en_pulses: got %0d want 3", n_en); end
    n_chk++;
    if (bz_log[12] !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_end_state: got busy %b err %b want 0 0", bz_log[12], err_o);
    end
  endtask

  task automatic test_backpressure;
    stub[0] = 8'h11; stub[1] = 8'h22; nstub = 2;
    launch(8'h01, 16'd1, 8'd2, 8'hFF);
    for (int c = 5; c < 10; c++) rdy_pat[c] = 1'b0;
    run(14);
    scan(14);
    for (int c = 5; c <= 10; c++) begin
      n_chk++;
      if (v_log[c] !== 1'b1 || a_log[c] !== 8'h22 || i_log[c] !== 16'd0 || en_log[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got v%b addr %h idx %0d en %b want v1 addr 22 idx 0 en 0",
                 c, v_log[c], a_log[c], i_log[c], en_log[c]);
      end
    end
    n_chk++;
    if (done_c !== 11 || n_hs !== 1) begin
      n_fail++; $display("FAIL bp_done: got c%0d hs %0d want c11 hs 1", done_c, n_hs);
    end
  endtask

  task automatic test_reject;
    stub[0] = 8'h80; stub[1] = 8'h12; nstub = 2;
    launch(8'h01, 16'd1, 8'd1, 8'h3F);
    run(10);
    scan(10);
    n_chk++;
    if (n_en !== 2 || n_v !== 1 || first_v !== 6) begin
      n_fail++; $display("FAIL reject_timing: got en %0d valid %0d first c%0d want 2 1 c6", n_en, n_v, first_v);
    end
    n_chk++;
    if (hs_addr[0] !== 8'h12 || er_log[9] !== 1'b0) begin
      n_fail++; $display("FAIL reject_addr: got addr %h err %b want 12 0", hs_addr[0], er_log[9]);
    end
  endtask

  task automatic test_errors;
    // Zero seed: immediate error, no lfsr activity.
    launch(8'h00, 16'd3, 8'd1, 8'hFF);
    run(5);
    scan(5);
    n_chk++;
    if (n_start !== 0 || n_en !== 0 || done_c !== 1 || er_log[1] !== 1'b1) begin
      n_fail++; $display("FAIL seed0: got start %0d en %0d done c%0d err %b want 0 0 c1 1",
                         n_start, n_en, done_c, er_log[1]);
    end
    // Lock-up value in CHECK; err from the previous campaign must clear on start.
    stub[0] = 8'h00; nstub = 1;
    launch(8'h01, 16'd2, 8'd1, 8'hFF);
    run(8);
    scan(8);
    n_chk++;
    if (er_log[1] !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b want 0", er_log[1]); end
    n_chk++;
    if (done_c !== 4 || er_log[4] !== 1'b1 || n_v !== 0) begin
      n_fail++; $display("FAIL lockup: got done c%0d err %b valid %0d want c4 1 0", done_c, er_log[4], n_v);
    end
    // Every candidate exceeds max: give up after 256 consecutive rejects.
    nstub = 0;
    launch(8'h01, 16'd1, 8'd1, 8'h00);
    run(520);
    scan(520);
    n_chk++;
    if (done_c !== 514 || er_log[514] !== 1'b1 || n_v !== 0 || n_en !== 256) begin
      n_fail++; $display("FAIL reject_limit: got done c%0d err %b valid %0d en %0d want c514 1 0 256",
                         done_c, er_log[514], n_v, n_en);
    end
  endtask

  task automatic test_abort;
    stub[0] = 8'h40; stub[1] = 8'h20; nstub = 2;
    launch(8'h01, 16'd3, 8'd1, 8'hFF);
    abt_pat[4] = 1'b1;
    run(8);
    scan(8);
    n_chk++;
    if (v_log[4] !== 1'b1 || v_log[5] !== 1'b0 || bz_log[5] !== 1'b0 || en_log[5] !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: got v4 %b v5 %b busy5 %b en5 %b want 1 0 0 0",
                         v_log[4], v_log[5], bz_log[5], en_log[5]);
    end
    n_chk++;
    if (i_log[5] !== 16'd0 || n_done !== 0) begin
      n_fail++; $display("FAIL abort_count: got idx %0d done %0d want 0 0", i_log[5], n_done);
    end
    launch(8'h01, 16'd1, 8'd1, 8'hFF);
    run(8);
    scan(8);
    n_chk++;
    if (first_v !== 4 || hs_addr[0] !== 8'h40 || hs_idx[0] !== 16'd0 || done_c !== 5) begin
      n_fail++; $display("FAIL abort_restart: got first c%0d addr %h idx %0d done c%0d want c4 40 0 c5",
                         first_v, hs_addr[0], hs_idx[0], done_c);
    end
  endtask

  task automatic test_zero_num_and_reset;
    logic [28:0] outs;
    launch(8'h01, 16'd0, 8'd1, 8'hFF);
    run(4);
    scan(4);
    n_chk++;
    if (done_c !== 1 || n_start !== 0 || n_en !== 0 || er_log[1] !== 1'b0) begin
      n_fail++; $display("FAIL num0: got done c%0d start %0d en %0d err %b want c1 0 0 0",
                         done_c, n_start, n_en, er_log[1]);
    end
    launch(8'h01, 16'd1, 8'd5, 8'hFF);
    run(3);
    n_chk++;
    if (lfsr_en_o !== 1'b1) begin n_fail++; $display("FAIL mid_step_pre: got en %b want 1", lfsr_en_o); end
    #2 rst_ni = 1'b0;
    #1;
    outs = {fif.valid, lfsr_start_o, lfsr_en_o, busy_o, done_o, err_o, fif.addr, fif.idx};
    n_chk++;
    if (outs !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", outs); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy_o !== 1'b0 || lfsr_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got busy %b en %b want 0 0", busy_o, lfsr_en_o);
    end
  endtask

  initial begin
    fif.ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_reject;
    test_errors;
    test_abort;
    test_zero_num_and_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
